uart_alu_interface: RTL
=======================

Name: uart_alu_interface

Overview:
- Consumes the byte stream from the UART receive stage (o_data / o_rx_done_tick) and assembles 3-byte frames: operand A, operand B, opcode.
- Presents A, B and opcode atomically to the ALU, captures the result one cycle later, and hands it to the UART transmit stage with a one-cycle start pulse.
- Waits for transmit completion before accepting the next frame.
- Sits between uart rx and the alu/uart tx pair in the TP2 datapath.

Parameters:
- NB_DATA, 8, width of rx byte, ALU operands, ALU result and tx byte
- NB_OP, 6, opcode width; low NB_OP bits of the third byte
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one frame before abort (>=2)
- NB_TIMEOUT, 20, timeout counter width; must hold TIMEOUT_CYCLES-1

Ports:
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done_tick=1
- i_rx_done_tick  in  1  one-cycle strobe from uart rx
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done_tick  in  1  one-cycle strobe from uart tx, byte fully sent
- o_alu_a  out  NB_DATA  registered operand A
- o_alu_b  out  NB_DATA  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- o_tx_data  out  NB_DATA  registered byte for uart tx
- o_tx_start  out  1  one-cycle start strobe to uart tx
- o_busy  out  1  high in LOAD, SEND, WAIT_TX
- o_drop_tick  out  1  one-cycle pulse: rx byte ignored while busy
- o_timeout_tick  out  1  one-cycle pulse: partial frame aborted

Behaviour:
- Reset (sync, i_reset=1 at edge): state=GET_A; all outputs 0; staging regs and timeout counter 0. Applies from any state, including mid-frame and while o_tx_start=1.
- States: GET_A, GET_B, GET_OP, LOAD, SEND, WAIT_TX. Registered outputs throughout.
- GET_A: on i_rx_done_tick capture byte into stage_a -> GET_B. No timeout counting.
- GET_B: on tick capture stage_b -> GET_OP.
- GET_OP: on tick (edge ending cycle n) load o_alu_a=stage_a, o_alu_b=stage_b, o_alu_op=i_rx_data[NB_OP-1:0] together -> LOAD. ALU operands update only here; held stable until the next frame's GET_OP completes.
- LOAD (cycle n+1): ALU settles; at edge capture o_tx_data=i_alu_result, o_tx_start<=1 -> SEND.
- SEND (cycle n+2): o_tx_start=1 exactly this cycle; cleared at edge -> WAIT_TX.
- WAIT_TX: on i_tx_done_tick -> GET_A. o_tx_data holds until next capture.
- i_tx_done_tick outside WAIT_TX is ignored.
- Timeout: in GET_B/GET_OP counter increments each cycle without rx tick and clears on an accepted byte. When counter = TIMEOUT_CYCLES-1 and no tick that cycle: -> GET_A, counter=0, o_timeout_tick=1 next cycle. A tick arriving on that same cycle wins (byte accepted, no timeout).
- Drop: i_rx_done_tick in LOAD, SEND or WAIT_TX produces o_drop_tick=1 the following cycle; the byte is discarded. This includes an rx tick on the same cycle as i_tx_done_tick in WAIT_TX (byte dropped, still -> GET_A).
- Latency: last rx tick to o_tx_start = 2 cycles.
- No arithmetic performed; opcode validity is the ALU's concern. Upper NB_DATA-NB_OP bits of opcode byte are discarded.

Decomposition:
- Shared package (uart_pkg): state encoding localparams, default NB_DATA/NB_OP, timeout default.
- One natural sub-module: frame_timeout_counter (clear, enable, expire pulse), parameterised by TIMEOUT_CYCLES/NB_TIMEOUT.
- FSM and output registers stay in uart_alu_interface.

Test Plan:
- Reset then rx 0x05, 0x03, 0x20; ALU model returns A+B -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20 one cycle after the third tick; o_tx_data=0x08 and o_tx_start=1 exactly 2 cycles after the third tick, single cycle.
- Opcode byte 0xE2 -> o_alu_op=0x22; operands unchanged from stage values.
- TIMEOUT_CYCLES=16: rx 0x11 then silence -> o_timeout_tick pulse after 16 idle cycles, state GET_A; next frame 0x01, 0x02, 0x20 yields o_tx_data=0x03.
- During WAIT_TX send rx byte 0x7F (incl. one coincident with i_tx_done_tick) -> o_drop_tick pulses; next frame starts clean with its own first byte as A.
- Assert i_reset in GET_OP and again during o_tx_start=1 -> next cycle all outputs 0, state GET_A, o_tx_start never re-asserts.
- Back-to-back frames with i_tx_done_tick 100 cycles after start -> o_busy high from LOAD to WAIT_TX exit, ALU operands stable throughout transmission.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and FSM state type for the uart/alu frame bridge.
package uart_pkg;
    localparam int NB_DATA_DEF    = 8;
    localparam int NB_OP_DEF      = 6;
    localparam int TIMEOUT_DEF    = 1000000;
    localparam int NB_TIMEOUT_DEF = 20;
    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, LOAD, SEND, WAIT_TX} state_t;
endpackage

// File: rtl/uart_alu_interface_if.sv
// uart_alu_interface_if: rx byte stream in, alu operands/result and tx handshake out.
interface uart_alu_interface_if
    import uart_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
);
    logic [NB_DATA-1:0] rx_data;
    logic               rx_done_tick;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done_tick;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               busy;
    logic               drop_tick;
    logic               timeout_tick;
    modport slave (
        input  rx_data, rx_done_tick, alu_result, tx_done_tick,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, drop_tick, timeout_tick
    );
    modport master (
        output rx_data, rx_done_tick, alu_result, tx_done_tick,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, drop_tick, timeout_tick
    );
endinterface

// File: rtl/uart_alu_interface_timeout.sv
// frame_timeout_counter: counts enabled idle cycles, pulses expire on the last allowed one.
module frame_timeout_counter
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int NB_TIMEOUT     = NB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [NB_TIMEOUT-1:0] cnt;
    assign expire = enable && cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        cnt <= (rst || clear || expire) ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: assembles A/B/opcode frames from uart rx, drives the alu, forwards its result to uart tx.
module uart_alu_interface
    import uart_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int NB_TIMEOUT     = NB_TIMEOUT_DEF
) (
    input logic                  i_clock,
    input logic                  i_reset,
    uart_alu_interface_if.slave  bus
);
    state_t             state, state_n;
    logic [NB_DATA-1:0] stage_a, stage_b;
    logic               expire, counting, tick, busy_n;
    assign tick     = bus.rx_done_tick;
    assign counting = state == GET_B || state == GET_OP;
    assign busy_n   = state_n inside {LOAD, SEND, WAIT_TX};
    frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .NB_TIMEOUT(NB_TIMEOUT)) timer (
        .clk(i_clock), .rst(i_reset), .clear(!counting || tick), .enable(counting && !tick), .expire(expire)
    );
    always_ff @(posedge i_clock)
        state <= i_reset ? GET_A : state_n;
    always_comb begin
        state_n = state;
        case (state)
            GET_A:   state_n = tick ? GET_B : GET_A;
            GET_B:   state_n = tick ? GET_OP : expire ? GET_A : GET_B;
            GET_OP:  state_n = tick ? LOAD : expire ? GET_A : GET_OP;
            LOAD:    state_n = SEND;
            SEND:    state_n = WAIT_TX;
            WAIT_TX: state_n = bus.tx_done_tick ? GET_A : WAIT_TX;
            default: state_n = GET_A;
        endcase
    end
    // Operands change only when a complete frame lands, so the alu input is never torn.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stage_a          <= '0;
            stage_b          <= '0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_op       <= '0;
            bus.tx_data      <= '0;
            bus.tx_start     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.drop_tick    <= 1'b0;
            bus.timeout_tick <= 1'b0;
        end else begin
            if (state == GET_A && tick) stage_a <= bus.rx_data;
            if (state == GET_B && tick) stage_b <= bus.rx_data;
            if (state == GET_OP && tick) begin
                bus.alu_a  <= stage_a;
                bus.alu_b  <= stage_b;
                bus.alu_op <= bus.rx_data[NB_OP-1:0];
            end
            if (state == LOAD) bus.tx_data <= bus.alu_result;
            bus.tx_start     <= state == LOAD;
            bus.busy         <= busy_n;
            bus.drop_tick    <= tick && state inside {LOAD, SEND, WAIT_TX};
            bus.timeout_tick <= expire;
        end
    end
endmodule
